// File: rtl/conv_encoder_frame_if.sv
// Frame-level bus between the board wrapper and the convolutional encoder.
// The master drives the start key and data word; the slave returns symbols and the packed codeword.
interface conv_encoder_frame_if #(
    parameter int SIZE_DATA_IN  = 8,
    parameter int SIZE_DATA_OUT = 16
);
    logic                     i_start;
    logic [SIZE_DATA_IN-1:0]  i_data;
    logic [1:0]               o_sym;
    logic                     o_sym_valid;
    logic [SIZE_DATA_OUT-1:0] o_code;
    logic                     o_busy;
    logic                     o_done;

    modport master (
        output i_start, i_data,
        input  o_sym, o_sym_valid, o_code, o_busy, o_done
    );

    modport slave (
        input  i_start, i_data,
        output o_sym, o_sym_valid, o_code, o_busy, o_done
    );
endinterface

// File: rtl/conv_encoder_frame.sv
// Rate-1/2, K=3 frame encoder: latches a byte on a start edge and emits one symbol per clock, MSB first.
// The packed codeword is truncated (no flush bits) and matches the Viterbi decoder's input format.
module conv_encoder_frame #(
    parameter int       SIZE_DATA_IN  = 8,
    parameter int       SIZE_DATA_OUT = 16,
    parameter bit [2:0] G0            = 3'b111,
    parameter bit [2:0] G1            = 3'b101
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    conv_encoder_frame_if.slave  bus
);
    localparam int               CNT_W    = $clog2(SIZE_DATA_IN);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SIZE_DATA_IN - 1);

    typedef enum logic [1:0] {IDLE, ENCODE, DONE} state_t;

    state_t                   state;
    state_t                   next_state;
    logic                     start_q;
    logic                     start_pulse;
    logic [SIZE_DATA_IN-1:0]  shift_reg;
    logic [SIZE_DATA_OUT-1:0] acc;
    logic [CNT_W-1:0]         bit_cnt;
    logic                     s1;
    logic                     s0;
    logic [2:0]               taps;
    logic                     g0;
    logic                     g1;
    logic                     load;
    logic                     shift_en;
    logic                     finish;

    assign start_pulse = bus.i_start & ~start_q;
    assign taps        = {shift_reg[SIZE_DATA_IN-1], s1, s0};
    assign g0          = ^(G0 & taps);
    assign g1          = ^(G1 & taps);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            start_q <= 1'b0;
        end else begin
            state   <= next_state;
            start_q <= bus.i_start;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: if (start_pulse)         next_state = ENCODE;
            ENCODE:     if (bit_cnt == LAST_BIT) next_state = DONE;
            default:                             next_state = IDLE;
        endcase
    end

    // A start edge seen while encoding is deliberately dropped.
    always_comb begin
        load     = 1'b0;
        shift_en = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE, DONE: load = start_pulse;
            ENCODE: begin
                shift_en = 1'b1;
                finish   = (bit_cnt == LAST_BIT);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift_reg       <= '0;
            acc             <= '0;
            bit_cnt         <= '0;
            s1              <= 1'b0;
            s0              <= 1'b0;
            bus.o_sym       <= 2'b00;
            bus.o_sym_valid <= 1'b0;
            bus.o_code      <= '0;
            bus.o_busy      <= 1'b0;
            bus.o_done      <= 1'b0;
        end else if (load) begin
            shift_reg       <= bus.i_data;
            acc             <= '0;
            bit_cnt         <= '0;
            s1              <= 1'b0;
            s0              <= 1'b0;
            bus.o_sym_valid <= 1'b0;
            bus.o_busy      <= 1'b1;
            bus.o_done      <= 1'b0;
        end else if (shift_en) begin
            shift_reg       <= {shift_reg[SIZE_DATA_IN-2:0], 1'b0};
            acc             <= {acc[SIZE_DATA_OUT-3:0], g0, g1};
            bit_cnt         <= bit_cnt + CNT_W'(1);
            s1              <= taps[2];
            s0              <= s1;
            bus.o_sym       <= {g0, g1};
            bus.o_sym_valid <= 1'b1;
            // o_code is published only here so it holds the previous frame while encoding.
            if (finish) begin
                bus.o_code <= {acc[SIZE_DATA_OUT-3:0], g0, g1};
                bus.o_busy <= 1'b0;
                bus.o_done <= 1'b1;
            end
        end else begin
            bus.o_sym_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_conv_encoder_frame.sv
// Self-checking bench for conv_encoder_frame: table-driven frames, a symbol scoreboard,
// and hand-written sequences for held keys, ignored restarts, mid-frame reset and back-to-back frames.
module tb_conv_encoder_frame;
    logic        clk = 1'b0;
    logic        rst_n;
    int          compared   = 0;
    int          mismatched = 0;
    logic [1:0]  exp_q[$];
    logic [15:0] last_code;
    int          done_rises;
    logic        prev_done;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] code;
    } vec_t;

    vec_t vecs[5];

    conv_encoder_frame_if bus();

    conv_encoder_frame dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Reference encoder written directly from the generator equations.
    task automatic pushExpected(input logic [7:0] d);
        logic s1 = 1'b0;
        logic s0 = 1'b0;
        logic u;
        for (int i = 7; i >= 0; i--) begin
            u = d[i];
            exp_q.push_back({u ^ s1 ^ s0, u ^ s0});
            s0 = s1;
            s1 = u;
        end
    endtask

    // Called on a negedge; drives one start pulse and checks latency and holding of o_code.
    task automatic applyStimulus(input logic [7:0] d, input logic [15:0] code);
        bus.i_data  = d;
        bus.i_start = 1'b1;
        pushExpected(d);
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_data  = ~d;
        checkOutput("busy_after_start", 16'(bus.o_busy), 16'd1);
        checkOutput("done_after_start", 16'(bus.o_done), 16'd0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k < 8) begin
                checkOutput("code_hold", bus.o_code, last_code);
                checkOutput("done_low", 16'(bus.o_done), 16'd0);
            end else begin
                checkOutput("code_final", bus.o_code, code);
                checkOutput("done_edge8", 16'(bus.o_done), 16'd1);
                checkOutput("busy_edge8", 16'(bus.o_busy), 16'd0);
            end
        end
        last_code = code;
        @(negedge clk);
        checkOutput("valid_in_done", 16'(bus.o_sym_valid), 16'd0);
        checkOutput("sb_drained", 16'(exp_q.size()), 16'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.o_sym_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL sym_unexpected: got %b, expected no symbol", bus.o_sym);
            end else begin
                checkOutput("sym", 16'(bus.o_sym), 16'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        vecs[0] = '{8'hB0, 16'hE170};
        vecs[1] = '{8'hFF, 16'hDAAA};
        vecs[2] = '{8'h00, 16'h0000};
        vecs[3] = '{8'h80, 16'hEC00};
        vecs[4] = '{8'h01, 16'h0003};

        rst_n       = 1'b0;
        bus.i_start = 1'b0;
        bus.i_data  = 8'h00;
        last_code   = 16'h0000;
        repeat (3) @(negedge clk);
        checkOutput("rst_sym", 16'(bus.o_sym), 16'd0);
        checkOutput("rst_valid", 16'(bus.o_sym_valid), 16'd0);
        checkOutput("rst_code", bus.o_code, 16'h0000);
        checkOutput("rst_busy", 16'(bus.o_busy), 16'd0);
        checkOutput("rst_done", 16'(bus.o_done), 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_busy", 16'(bus.o_busy), 16'd0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].data, vecs[i].code);
        end

        $display("[TB] held start key");
        bus.i_data  = 8'hB0;
        bus.i_start = 1'b1;
        pushExpected(8'hB0);
        done_rises = 0;
        prev_done  = bus.o_done;
        for (int c = 0; c < 35; c++) begin
            @(negedge clk);
            if (c == 29) bus.i_start = 1'b0;
            if (bus.o_done && !prev_done) done_rises++;
            prev_done = bus.o_done;
        end
        checkOutput("hold_one_frame", 16'(done_rises), 16'd1);
        checkOutput("hold_code", bus.o_code, 16'hE170);
        checkOutput("hold_sb_drained", 16'(exp_q.size()), 16'd0);
        last_code = 16'hE170;

        $display("[TB] restart during encode");
        bus.i_data  = 8'h80;
        bus.i_start = 1'b1;
        pushExpected(8'h80);
        done_rises = 0;
        prev_done  = bus.o_done;
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_data  = 8'hFF;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c == 3) bus.i_start = 1'b1;
            if (c == 4) bus.i_start = 1'b0;
            if (bus.o_done && !prev_done) done_rises++;
            prev_done = bus.o_done;
        end
        checkOutput("ignored_restart", 16'(done_rises), 16'd1);
        checkOutput("ignored_code", bus.o_code, 16'hEC00);
        checkOutput("ignored_sb_drained", 16'(exp_q.size()), 16'd0);
        last_code = 16'hEC00;

        $display("[TB] back-to-back frames");
        applyStimulus(8'hB0, 16'hE170);
        applyStimulus(8'h80, 16'hEC00);

        $display("[TB] reset mid-frame");
        bus.i_data  = 8'hB0;
        bus.i_start = 1'b1;
        pushExpected(8'hB0);
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        checkOutput("abort_sym", 16'(bus.o_sym), 16'd0);
        checkOutput("abort_valid", 16'(bus.o_sym_valid), 16'd0);
        checkOutput("abort_code", bus.o_code, 16'h0000);
        checkOutput("abort_busy", 16'(bus.o_busy), 16'd0);
        checkOutput("abort_done", 16'(bus.o_done), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("post_abort_busy", 16'(bus.o_busy), 16'd0);
        checkOutput("post_abort_code", bus.o_code, 16'h0000);
        last_code = 16'h0000;
        applyStimulus(8'hB0, 16'hE170);

        repeat (3) @(negedge clk);
        checkOutput("final_sb_empty", 16'(exp_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
